// File: rtl/boot_loader.sv
// boot_loader: receives a big-endian byte stream (addr, len, data words), writes
// the words to memory, then releases the CPU from reset until a reload request.
`default_nettype none

module boot_loader (
  input  logic        clk,
  input  logic        RST_bar,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        load_req,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data,
  output logic        mem_we,
  output logic        cpu_rst_bar,
  output logic        busy,
  output logic [15:0] words_left
);

  typedef enum logic [2:0] {
    S_ADDR_H = 3'd0,
    S_ADDR_L = 3'd1,
    S_LEN_H  = 3'd2,
    S_LEN_L  = 3'd3,
    S_DATA_H = 3'd4,
    S_DATA_L = 3'd5,
    S_WRITE  = 3'd6,
    S_RUN    = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  len_h_q, len_h_d;
  logic [15:0] words_left_q, words_left_d;
  logic [7:0]  data_h_q, data_h_d;
  logic [7:0]  data_l_q, data_l_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_data_q, mem_data_d;
  logic        cpu_rst_bar_q, cpu_rst_bar_d;
  logic        accept;

  // Outputs decode registered state only; no input reaches an output combinationally.
  assign rx_ready    = (state_q != S_WRITE) && (state_q != S_RUN);
  assign mem_we      = (state_q == S_WRITE);
  assign busy        = (state_q != S_RUN);
  assign mem_addr    = mem_addr_q;
  assign mem_data    = mem_data_q;
  assign cpu_rst_bar = cpu_rst_bar_q;
  assign words_left  = words_left_q;

  assign accept = rx_valid && rx_ready;

  always_ff @(posedge clk) begin
    if (!RST_bar) begin
      state_q       <= S_ADDR_H;
      addr_q        <= 16'h0000;
      len_h_q       <= 8'h00;
      words_left_q  <= 16'h0000;
      data_h_q      <= 8'h00;
      data_l_q      <= 8'h00;
      mem_addr_q    <= 16'h0000;
      mem_data_q    <= 16'h0000;
      cpu_rst_bar_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      len_h_q       <= len_h_d;
      words_left_q  <= words_left_d;
      data_h_q      <= data_h_d;
      data_l_q      <= data_l_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_q    <= mem_data_d;
      cpu_rst_bar_q <= cpu_rst_bar_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    len_h_d       = len_h_q;
    words_left_d  = words_left_q;
    data_h_d      = data_h_q;
    data_l_d      = data_l_q;
    mem_addr_d    = mem_addr_q;
    mem_data_d    = mem_data_q;
    // CPU is released one cycle after RUN is entered and dropped with the reload request.
    cpu_rst_bar_d = (state_q == S_RUN) && !load_req;

    case (state_q)
      S_ADDR_H: if (accept) begin
        addr_d[15:8] = rx_data;
        state_d      = S_ADDR_L;
      end
      S_ADDR_L: if (accept) begin
        addr_d[7:0] = rx_data;
        state_d     = S_LEN_H;
      end
      S_LEN_H: if (accept) begin
        len_h_d = rx_data;
        state_d = S_LEN_L;
      end
      S_LEN_L: if (accept) begin
        words_left_d = {len_h_q, rx_data};
        state_d      = ({len_h_q, rx_data} != 16'h0000) ? S_DATA_H : S_RUN;
      end
      S_DATA_H: if (accept) begin
        data_h_d = rx_data;
        state_d  = S_DATA_L;
      end
      S_DATA_L: if (accept) begin
        // Memory port registers are loaded here so they are valid throughout WRITE.
        data_l_d   = rx_data;
        mem_addr_d = addr_q;
        mem_data_d = {data_h_q, rx_data};
        state_d    = S_WRITE;
      end
      S_WRITE: begin
        addr_d       = addr_q + 16'd1;
        words_left_d = words_left_q - 16'd1;
        state_d      = (words_left_q == 16'd1) ? S_RUN : S_DATA_H;
      end
      S_RUN: if (load_req) begin
        state_d = S_ADDR_H;
      end
      default: state_d = S_ADDR_H;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_boot_loader.sv
// Directed self-checking bench for boot_loader.
`default_nettype none

module tb_boot_loader;

  logic        clk = 1'b0;
  logic        RST_bar;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        load_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_we;
  logic        cpu_rst_bar;
  logic        busy;
  logic [15:0] words_left;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_wr = 0;
  int bad_rdy = 0;
  logic [15:0] wr_addr [64];
  logic [15:0] wr_data [64];
  int first_edge;
  int rise_edge;
  int base;

  always #5 clk = ~clk;

  boot_loader dut (
    .clk         (clk),
    .RST_bar     (RST_bar),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .load_req    (load_req),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_we      (mem_we),
    .cpu_rst_bar (cpu_rst_bar),
    .busy        (busy),
    .words_left  (words_left)
  );

  // Write log: every cycle with mem_we high is one recorded write.
  always @(posedge clk) begin
    if (mem_we) begin
      if (n_wr < 64) begin
        wr_addr[n_wr] <= mem_addr;
        wr_data[n_wr] <= mem_data;
      end
      n_wr <= n_wr + 1;
      if (rx_ready) bad_rdy <= bad_rdy + 1;
    end
    cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit thr);
    int g;
    if (thr) begin
      rx_valid = 1'b0;
      @(negedge clk);
    end
    rx_data  = b;
    rx_valid = 1'b1;
    g = 0;
    while (!rx_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!rx_ready) chk("accept_timeout", {31'd0, rx_ready}, 32'd1);
    if (first_edge < 0) first_edge = cyc;
    @(negedge clk);
  endtask

  task automatic send_stream(input logic [63:0] v, input int n, input bit thr);
    logic [63:0] t;
    t = v;
    first_edge = -1;
    for (int i = 0; i < n; i++) send_byte(t[63-8*i -: 8], thr);
    rx_valid = 1'b0;
  endtask

  task automatic wait_run(input string tag);
    int g;
    g = 0;
    while (!cpu_rst_bar && g < 60) begin
      @(negedge clk);
      g++;
    end
    rise_edge = cyc - 1;
    chk({tag, "_cpu_rel"}, {31'd0, cpu_rst_bar}, 32'd1);
  endtask

  task automatic reload(input string tag);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    chk({tag, "_cpurst"}, {31'd0, cpu_rst_bar}, 32'd0);
    chk({tag, "_busy"},   {31'd0, busy},        32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    RST_bar  = 1'b0;
    rx_data  = 8'h77;
    rx_valid = 1'b1;
    load_req = 1'b0;
    first_edge = -1;
    rise_edge  = -1;
    repeat (3) @(negedge clk);
    rx_valid = 1'b0;
    chk("rst_we",      {31'd0, mem_we},      32'd0);
    chk("rst_ready",   {31'd0, rx_ready},    32'd1);
    chk("rst_busy",    {31'd0, busy},        32'd1);
    chk("rst_cpurst",  {31'd0, cpu_rst_bar}, 32'd0);
    chk("rst_wleft",   {16'd0, words_left},  32'h0);
    chk("rst_maddr",   {16'd0, mem_addr},    32'h0);
    chk("rst_mdata",   {16'd0, mem_data},    32'h0);
    RST_bar = 1'b1;
    @(negedge clk);

    // Basic load
    base = n_wr;
    send_stream(64'h0100_0002_ABCD_1234, 8, 1'b0);
    wait_run("basic");
    chk("basic_nwr",    n_wr - base,                 32'd2);
    chk("basic_a0",     {16'd0, wr_addr[base]},      32'h0100);
    chk("basic_d0",     {16'd0, wr_data[base]},      32'hABCD);
    chk("basic_a1",     {16'd0, wr_addr[base+1]},    32'h0101);
    chk("basic_d1",     {16'd0, wr_data[base+1]},    32'h1234);
    chk("basic_rise",   rise_edge - first_edge,      32'd10);
    chk("basic_wleft",  {16'd0, words_left},         32'h0);
    chk("basic_busy",   {31'd0, busy},               32'd0);
    chk("basic_hold_a", {16'd0, mem_addr},           32'h0101);
    chk("basic_hold_d", {16'd0, mem_data},           32'h1234);

    // Zero-length load
    reload("rl1");
    base = n_wr;
    send_stream(64'h2000_0000_0000_0000, 4, 1'b0);
    chk("zero_busy",   {31'd0, busy},       32'd0);
    chk("zero_we",     {31'd0, mem_we},     32'd0);
    wait_run("zero");
    chk("zero_nwr",    n_wr - base,         32'd0);
    chk("zero_wleft",  {16'd0, words_left}, 32'h0);
    chk("zero_hold_a", {16'd0, mem_addr},   32'h0101);

    // Address wrap
    reload("rl2");
    base = n_wr;
    send_stream(64'hFFFF_0002_1111_2222, 8, 1'b0);
    wait_run("wrap");
    chk("wrap_nwr", n_wr - base,              32'd2);
    chk("wrap_a0",  {16'd0, wr_addr[base]},   32'hFFFF);
    chk("wrap_d0",  {16'd0, wr_data[base]},   32'h1111);
    chk("wrap_a1",  {16'd0, wr_addr[base+1]}, 32'h0000);
    chk("wrap_d1",  {16'd0, wr_data[base+1]}, 32'h2222);

    // Throttled source
    reload("rl3");
    base = n_wr;
    send_stream(64'h0100_0002_ABCD_1234, 8, 1'b1);
    wait_run("thr");
    chk("thr_nwr",    n_wr - base,              32'd2);
    chk("thr_a0",     {16'd0, wr_addr[base]},   32'h0100);
    chk("thr_d0",     {16'd0, wr_data[base]},   32'hABCD);
    chk("thr_a1",     {16'd0, wr_addr[base+1]}, 32'h0101);
    chk("thr_d1",     {16'd0, wr_data[base+1]}, 32'h1234);
    chk("thr_rdy_wr", bad_rdy,                  32'd0);

    // load_req during DATA_H is ignored
    reload("rl4");
    base = n_wr;
    send_stream(64'h0300_0001_0000_0000, 4, 1'b0);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    chk("ldreq_busy",  {31'd0, busy},       32'd1);
    chk("ldreq_ready", {31'd0, rx_ready},   32'd1);
    chk("ldreq_wleft", {16'd0, words_left}, 32'h1);
    send_stream(64'h5AA5_0000_0000_0000, 2, 1'b0);
    wait_run("ldreq");
    chk("ldreq_nwr", n_wr - base,            32'd1);
    chk("ldreq_a0",  {16'd0, wr_addr[base]}, 32'h0300);
    chk("ldreq_d0",  {16'd0, wr_data[base]}, 32'h5AA5);

    // Reset while in WRITE
    reload("rl5");
    send_stream(64'h0100_0002_ABCD_0000, 6, 1'b0);
    chk("mid_pre_we", {31'd0, mem_we}, 32'd1);
    RST_bar  = 1'b0;
    rx_data  = 8'h55;
    rx_valid = 1'b1;
    @(negedge clk);
    chk("mid_we",     {31'd0, mem_we},      32'd0);
    chk("mid_ready",  {31'd0, rx_ready},    32'd1);
    chk("mid_busy",   {31'd0, busy},        32'd1);
    chk("mid_wleft",  {16'd0, words_left},  32'h0);
    chk("mid_maddr",  {16'd0, mem_addr},    32'h0);
    chk("mid_cpurst", {31'd0, cpu_rst_bar}, 32'd0);
    RST_bar  = 1'b1;
    rx_valid = 1'b0;
    base = n_wr;
    @(negedge clk);
    chk("mid_we_after", {31'd0, mem_we}, 32'd0);
    send_stream(64'h0400_0002_CAFE_BEEF, 8, 1'b0);
    wait_run("fresh");
    chk("fresh_nwr", n_wr - base,              32'd2);
    chk("fresh_a0",  {16'd0, wr_addr[base]},   32'h0400);
    chk("fresh_d0",  {16'd0, wr_data[base]},   32'hCAFE);
    chk("fresh_a1",  {16'd0, wr_addr[base+1]}, 32'h0401);
    chk("fresh_d1",  {16'd0, wr_data[base+1]}, 32'hBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
